// File: rtl/ls161_timer_pkg.sv
// rtl/ls161_timer_pkg.sv - shared types and default widths for the LS161 chain timer controller
package ls161_timer_pkg;

    localparam int STAGE_W      = 4;
    localparam int DEF_STAGES   = 2;
    localparam int DEF_REPEAT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/ls161_timer_repcnt.sv
// rtl/ls161_timer_repcnt.sv - remaining-period down-counter with load, decrement and zero flag
module ls161_timer_repcnt #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CLR_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_zero
);

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/ls161_timer_ctrl.sv
// rtl/ls161_timer_ctrl.sv - command-driven sequencer for a cascade of LS161-style counters
// Optional pause input is built in when LS161_TIMER_PAUSE_EN is defined.
module ls161_timer_ctrl
    import ls161_timer_pkg::*;
#(
    parameter int STAGES   = DEF_STAGES,
    parameter int REPEAT_W = DEF_REPEAT_W
) (
    input  logic                        CLK,
    input  logic                        CLR_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [STAGE_W*STAGES-1:0]   cmd_preset,
    input  logic [REPEAT_W-1:0]         cmd_repeat,
    input  logic                        cmd_periodic,
    input  logic                        stop,
`ifdef LS161_TIMER_PAUSE_EN
    input  logic                        pause,
`endif
    input  logic                        cnt_rco,
    output logic                        cnt_load_n,
    output logic                        cnt_enp,
    output logic                        cnt_ent,
    output logic [STAGE_W*STAGES-1:0]   cnt_d,
    output logic                        tick,
    output logic                        done,
    output logic                        busy
);

    localparam int N = STAGE_W * STAGES;

    state_t              state;
    state_t              state_n;
    logic [N-1:0]        preset_q;
    logic                periodic_q;
    logic                tick_q;
    logic                done_q;
    logic [REPEAT_W-1:0] rep_count;
    logic                rep_zero;
    logic                accept;
    logic                hold;
    logic                last;
    logic                tc_live;

`ifdef LS161_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign last      = ~periodic_q & rep_zero;
    // A terminal count only counts when neither stop nor pause is masking it.
    assign tc_live   = (state == RUN) & cnt_rco & ~stop & ~hold;

    ls161_timer_repcnt #(
        .W (REPEAT_W)
    ) u_repcnt (
        .CLK      (CLK),
        .CLR_n    (CLR_n),
        .load     (accept),
        .load_val (cmd_periodic ? '0 : cmd_repeat),
        .dec      (tc_live & ~last & ~periodic_q),
        .count    (rep_count),
        .is_zero  (rep_zero)
    );

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state      <= IDLE;
            preset_q   <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_n;
            tick_q <= tc_live;
            done_q <= tc_live & last;
            if (accept) begin
                preset_q   <= cmd_preset;
                periodic_q <= cmd_periodic;
            end
        end
    end

    // ENT is a pure function of state so cnt_rco never feeds back into it.
    always_comb begin
        state_n    = state;
        cnt_load_n = 1'b1;
        cnt_enp    = 1'b0;
        cnt_ent    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_n = LOAD;
            end
            LOAD: begin
                cnt_load_n = 1'b0;
                state_n    = stop ? IDLE : RUN;
            end
            RUN: begin
                cnt_ent = 1'b1;
                if (stop) begin
                    state_n = IDLE;
                end else if (!hold) begin
                    cnt_load_n = ~(cnt_rco & ~last);
                    cnt_enp    = ~(cnt_rco & last);
                    if (cnt_rco && last) state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign cnt_d = preset_q;
    assign tick  = tick_q;
    assign done  = done_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_ls161_timer_ctrl.sv
// tb/tb_ls161_timer_ctrl.sv - scoreboard bench for ls161_timer_ctrl with an 8-bit chain model
module tb_ls161_timer_ctrl;

    logic       CLK = 1'b0;
    logic       CLR_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_preset = 8'h00;
    logic [7:0] cmd_repeat = 8'h00;
    logic       cmd_periodic = 1'b0;
    logic       stop = 1'b0;
`ifdef LS161_TIMER_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       cnt_rco;
    logic       cnt_load_n;
    logic       cnt_enp;
    logic       cnt_ent;
    logic [7:0] cnt_d;
    logic       tick;
    logic       done;
    logic       busy;

    logic [7:0] q = 8'h00;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         cyc;
        logic       done;
        logic [7:0] q;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    ls161_timer_ctrl #(.STAGES(2), .REPEAT_W(8)) dut (
        .CLK          (CLK),
        .CLR_n        (CLR_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_preset   (cmd_preset),
        .cmd_repeat   (cmd_repeat),
        .cmd_periodic (cmd_periodic),
        .stop         (stop),
`ifdef LS161_TIMER_PAUSE_EN
        .pause        (pause),
`endif
        .cnt_rco      (cnt_rco),
        .cnt_load_n   (cnt_load_n),
        .cnt_enp      (cnt_enp),
        .cnt_ent      (cnt_ent),
        .cnt_d        (cnt_d),
        .tick         (tick),
        .done         (done),
        .busy         (busy)
    );

    // Chain model: 8-bit synchronous counter, not cleared by CLR_n.
    assign cnt_rco = cnt_ent && (q == 8'hFF);
    always @(posedge CLK) begin
        if (!cnt_load_n) q <= cnt_d;
        else if (cnt_enp && cnt_ent) q <= q + 8'd1;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic d, input logic [7:0] qq);
        exp_t e;
        e.cyc  = c;
        e.done = d;
        e.q    = qq;
        exp_q.push_back(e);
    endtask

    task automatic issue_cmd(input logic [7:0] p, input logic [7:0] r, input logic per, output int a);
        @(negedge CLK);
        cmd_preset   = p;
        cmd_repeat   = r;
        cmd_periodic = per;
        cmd_valid    = 1'b1;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge CLK);
        #1;
        a = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge CLK);
        repeat (5) @(negedge CLK);
        check("scoreboard_drain", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every tick/done presented by the DUT must match the next expected event.
    always @(negedge CLK) begin
        exp_t e;
        if (CLR_n && (tick || done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, tick, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_tick", {31'd0, tick}, 32'd1);
                check("event_done", {31'd0, done}, {31'd0, e.done});
                check("event_chain_q", {24'd0, q}, {24'd0, e.q});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;

        #12;
        check("rst_load_n", {31'd0, cnt_load_n}, 32'd1);
        check("rst_enp", {31'd0, cnt_enp}, 32'd0);
        check("rst_ent", {31'd0, cnt_ent}, 32'd0);
        check("rst_d", {24'd0, cnt_d}, 32'd0);
        check("rst_busy_tick_done", {29'd0, busy, tick, done}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge CLK);
        CLR_n = 1'b1;
        repeat (2) @(negedge CLK);

        // One-shot P=0xFA: LOAD cycle, then tick+done 7 cycles after accept.
        issue_cmd(8'hFA, 8'd0, 1'b0, a);
        push_exp(a + 7, 1'b1, 8'hFF);
        check("load_cycle_load_n", {31'd0, cnt_load_n}, 32'd0);
        check("load_cycle_busy", {31'd0, busy}, 32'd1);
        drain();
        check("oneshot_hold_ff", {24'd0, q}, 32'h0000_00FF);

        // P=0xF0, R=2: three ticks 16 apart, reloads to 0xF0 on the first two.
        issue_cmd(8'hF0, 8'd2, 1'b0, a);
        push_exp(a + 17, 1'b0, 8'hF0);
        push_exp(a + 33, 1'b0, 8'hF0);
        push_exp(a + 49, 1'b1, 8'hFF);
        wait_cyc(a + 5);
        check("busy_not_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_preset = 8'h11;
        cmd_valid  = 1'b1;
        @(negedge CLK);
        cmd_valid  = 1'b0;
        check("cmd_ignored_d", {24'd0, cnt_d}, 32'h0000_00F0);
        drain();

        // Periodic P=0xFF: tick each cycle, stop after the 10th.
        issue_cmd(8'hFF, 8'd0, 1'b1, a);
        for (int k = 0; k < 10; k++) push_exp(a + 2 + k, 1'b0, 8'hFF);
        wait_cyc(a + 11);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_enp_ent", {30'd0, cnt_enp, cnt_ent}, 32'd0);
        check("stop_ready", {31'd0, cmd_ready}, 32'd1);
        drain();

        // P=0xFA, R=1: stop lands on the final terminal-count cycle.
        issue_cmd(8'hFA, 8'd1, 1'b0, a);
        push_exp(a + 7, 1'b0, 8'hFA);
        wait_cyc(a + 12);
        check("tc_cycle_rco", {31'd0, cnt_rco}, 32'd1);
        stop = 1'b1;
        #1;
        check("stop_tc_load_n", {31'd0, cnt_load_n}, 32'd1);
        check("stop_tc_enp", {31'd0, cnt_enp}, 32'd0);
        @(negedge CLK);
        stop = 1'b0;
        check("stop_tc_busy", {31'd0, busy}, 32'd0);
        check("stop_tc_no_event", {30'd0, tick, done}, 32'd0);
        check("stop_tc_frozen", {24'd0, q}, 32'h0000_00FF);
        drain();

        // Asynchronous reset mid-run, then a fresh one-shot.
        issue_cmd(8'hF0, 8'd0, 1'b0, a);
        wait_cyc(a + 6);
        #2;
        CLR_n = 1'b0;
        #1;
        check("amid_load_n", {31'd0, cnt_load_n}, 32'd1);
        check("amid_enp_ent", {30'd0, cnt_enp, cnt_ent}, 32'd0);
        check("amid_d", {24'd0, cnt_d}, 32'd0);
        check("amid_busy_tick_done", {29'd0, busy, tick, done}, 32'd0);
        check("amid_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge CLK);
        CLR_n = 1'b1;
        issue_cmd(8'hFC, 8'd0, 1'b0, a);
        push_exp(a + 5, 1'b1, 8'hFF);
        drain();

`ifdef LS161_TIMER_PAUSE_EN
        // Pause 7 cycles mid-period: single period stretched by 7.
        issue_cmd(8'hF0, 8'd0, 1'b0, a);
        push_exp(a + 24, 1'b1, 8'hFF);
        wait_cyc(a + 5);
        pause = 1'b1;
        repeat (7) @(negedge CLK);
        pause = 1'b0;
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
